// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM period generator.
package pwm_pkg;

  localparam int unsigned PWM_DATA_WIDTH = 13;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/pwm_period_generator_period_counter.sv
// Free-running period counter: counts 0..period_i, clears when disabled.
module period_counter
  import pwm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PWM_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] period_i,
  output logic [DATA_WIDTH-1:0] cnt_o,
  output logic                  wrap_o
);

  logic [DATA_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] cnt_d;

  // cnt_q never exceeds period_i, so the increment cannot overflow
  always_comb begin
    wrap_o = en_i && (cnt_q == period_i);
    cnt_d  = cnt_q + DATA_WIDTH'(1);
    if (!en_i || wrap_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pwm_period_generator.sv
// PWM period/duty generator with double-buffered config; commits on wrap or while disabled.
// state   | meaning
// IDLE    | no update pending, cfg_ready_o high
// PENDING | pair held in pend regs, waiting for wrap or disabled cycle
module pwm_period_generator
  import pwm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PWM_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [DATA_WIDTH-1:0] period_i,
  input  logic [DATA_WIDTH-1:0] duty_i,
  output logic [DATA_WIDTH-1:0] cnt_o,
  output logic [DATA_WIDTH-1:0] duty_o,
  input  logic                  lt_i,
  output logic                  pwm_o,
  output logic                  period_end_o
);

  logic [DATA_WIDTH-1:0] period_act_q, period_act_d;
  logic [DATA_WIDTH-1:0] duty_act_q, duty_act_d;
  logic [DATA_WIDTH-1:0] period_pend_q, period_pend_d;
  logic [DATA_WIDTH-1:0] duty_pend_q, duty_pend_d;
  cfg_state_t            state_q, state_d;
  logic                  pwm_q, pwm_d;
  logic                  period_end_q, period_end_d;
  logic                  wrap;

  period_counter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_period_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .period_i (period_act_q),
    .cnt_o    (cnt_o),
    .wrap_o   (wrap)
  );

  assign cfg_ready_o = (state_q == IDLE);

  // Acceptance in IDLE never commits in the same cycle, even on a wrap
  always_comb begin
    state_d       = state_q;
    period_act_d  = period_act_q;
    duty_act_d    = duty_act_q;
    period_pend_d = period_pend_q;
    duty_pend_d   = duty_pend_q;
    if (state_q == IDLE) begin
      if (cfg_valid_i) begin
        period_pend_d = period_i;
        duty_pend_d   = duty_i;
        state_d       = PENDING;
      end
    end else begin
      if (wrap || !en_i) begin
        period_act_d = period_pend_q;
        duty_act_d   = duty_pend_q;
        state_d      = IDLE;
      end
    end
  end

  always_comb begin
    pwm_d        = en_i && lt_i;
    period_end_d = wrap;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      period_act_q  <= '0;
      duty_act_q    <= '0;
      period_pend_q <= '0;
      duty_pend_q   <= '0;
      pwm_q         <= 1'b0;
      period_end_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_act_q  <= period_act_d;
      duty_act_q    <= duty_act_d;
      period_pend_q <= period_pend_d;
      duty_pend_q   <= duty_pend_d;
      pwm_q         <= pwm_d;
      period_end_q  <= period_end_d;
    end
  end

  assign duty_o       = duty_act_q;
  assign pwm_o        = pwm_q;
  assign period_end_o = period_end_q;

endmodule

// File: tb/tb_pwm_period_generator.sv
// Directed bench for pwm_period_generator; the comparator is modelled inline.
module tb_pwm_period_generator;

  localparam int DW = 13;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic          cfg_valid_i = 1'b0;
  logic [DW-1:0] period_i = '0;
  logic [DW-1:0] duty_i = '0;
  logic          cfg_ready_o;
  logic [DW-1:0] cnt_o;
  logic [DW-1:0] duty_o;
  logic          lt_i;
  logic          pwm_o;
  logic          period_end_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  assign lt_i = (cnt_o < duty_o);

  pwm_period_generator #(.DATA_WIDTH(DW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .period_i     (period_i),
    .duty_i       (duty_i),
    .cnt_o        (cnt_o),
    .duty_o       (duty_o),
    .lt_i         (lt_i),
    .pwm_o        (pwm_o),
    .period_end_o (period_end_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_cnt(input logic [DW-1:0] target);
    int n;
    n = 0;
    while (cnt_o !== target && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (cnt_o !== target) begin
      failures++;
      $display("FAIL wait_cnt cnt_o=%0d wanted=%0d (timeout)", cnt_o, target);
    end
  endtask

  // Loads a pair while disabled: accept edge, then commit edge.
  task automatic load_cfg(input logic [DW-1:0] p, input logic [DW-1:0] d);
    en_i        = 1'b0;
    period_i    = p;
    duty_i      = d;
    cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    checks++; if (cnt_o !== '0) begin failures++; $display("FAIL reset_cnt cnt_o=%0d expected=0", cnt_o); end
    checks++; if (duty_o !== '0) begin failures++; $display("FAIL reset_duty duty_o=%0d expected=0", duty_o); end
    checks++; if (pwm_o !== 1'b0) begin failures++; $display("FAIL reset_pwm pwm_o=%b expected=0", pwm_o); end
    checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready cfg_ready_o=%b expected=1", cfg_ready_o); end
    checks++; if (period_end_o !== 1'b0) begin failures++; $display("FAIL reset_pe period_end_o=%b expected=0", period_end_o); end
  endtask

  task automatic test_basic_pwm();
    logic          exp_pwm, exp_pe;
    logic [DW-1:0] exp_cnt;
    en_i        = 1'b0;
    period_i    = DW'(9);
    duty_i      = DW'(3);
    cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    checks++; if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL basic_accept_ready cfg_ready_o=%b expected=0", cfg_ready_o); end
    tick();
    checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL basic_commit_ready cfg_ready_o=%b expected=1", cfg_ready_o); end
    checks++; if (duty_o !== DW'(3)) begin failures++; $display("FAIL basic_commit_duty duty_o=%0d expected=3", duty_o); end
    en_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_pwm = ((k - 1) % 10) < 3;
      exp_pe  = ((k - 1) % 10) == 9;
      exp_cnt = DW'(k % 10);
      checks++; if (pwm_o !== exp_pwm) begin failures++; $display("FAIL basic_pwm k=%0d pwm_o=%b expected=%b", k, pwm_o, exp_pwm); end
      checks++; if (period_end_o !== exp_pe) begin failures++; $display("FAIL basic_pe k=%0d period_end_o=%b expected=%b", k, period_end_o, exp_pe); end
      checks++; if (cnt_o !== exp_cnt) begin failures++; $display("FAIL basic_cnt k=%0d cnt_o=%0d expected=%0d", k, cnt_o, exp_cnt); end
    end
  endtask

  task automatic test_boundary_commit();
    logic          exp_pwm, exp_pe;
    logic [DW-1:0] exp_cnt;
    wait_cnt(DW'(5));
    period_i    = DW'(4);
    duty_i      = DW'(2);
    cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    checks++; if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL bnd_ready_low cfg_ready_o=%b expected=0", cfg_ready_o); end
    checks++; if (cnt_o !== DW'(6)) begin failures++; $display("FAIL bnd_cnt6 cnt_o=%0d expected=6", cnt_o); end
    checks++; if (pwm_o !== 1'b0) begin failures++; $display("FAIL bnd_pwm5 pwm_o=%b expected=0", pwm_o); end
    period_i    = DW'(7);
    duty_i      = DW'(7);
    cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    checks++; if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL bnd_still_pending cfg_ready_o=%b expected=0", cfg_ready_o); end
    tick();
    tick();
    checks++; if (cnt_o !== DW'(9)) begin failures++; $display("FAIL bnd_old_cnt9 cnt_o=%0d expected=9", cnt_o); end
    checks++; if (duty_o !== DW'(3)) begin failures++; $display("FAIL bnd_old_duty duty_o=%0d expected=3", duty_o); end
    tick();
    checks++; if (cnt_o !== '0) begin failures++; $display("FAIL bnd_wrap_cnt cnt_o=%0d expected=0", cnt_o); end
    checks++; if (period_end_o !== 1'b1) begin failures++; $display("FAIL bnd_wrap_pe period_end_o=%b expected=1", period_end_o); end
    checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL bnd_ready_high cfg_ready_o=%b expected=1", cfg_ready_o); end
    checks++; if (duty_o !== DW'(2)) begin failures++; $display("FAIL bnd_new_duty duty_o=%0d expected=2", duty_o); end
    for (int j = 1; j <= 10; j++) begin
      tick();
      exp_pwm = ((j - 1) % 5) < 2;
      exp_pe  = ((j - 1) % 5) == 4;
      exp_cnt = DW'(j % 5);
      checks++; if (pwm_o !== exp_pwm) begin failures++; $display("FAIL bnd_pwm j=%0d pwm_o=%b expected=%b", j, pwm_o, exp_pwm); end
      checks++; if (period_end_o !== exp_pe) begin failures++; $display("FAIL bnd_pe j=%0d period_end_o=%b expected=%b", j, period_end_o, exp_pe); end
      checks++; if (cnt_o !== exp_cnt) begin failures++; $display("FAIL bnd_cnt j=%0d cnt_o=%0d expected=%0d", j, cnt_o, exp_cnt); end
    end
    checks++; if (duty_o !== DW'(2)) begin failures++; $display("FAIL bnd_ignored_pair duty_o=%0d expected=2", duty_o); end
    checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL bnd_ready_idle cfg_ready_o=%b expected=1", cfg_ready_o); end
  endtask

  task automatic test_duty_edges();
    load_cfg(DW'(9), DW'(0));
    en_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++; if (pwm_o !== 1'b0) begin failures++; $display("FAIL duty0_pwm k=%0d pwm_o=%b expected=0", k, pwm_o); end
    end
    load_cfg(DW'(4), DW'(5));
    en_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++; if (pwm_o !== 1'b1) begin failures++; $display("FAIL dutyhi_pwm k=%0d pwm_o=%b expected=1", k, pwm_o); end
    end
    load_cfg(DW'(0), DW'(0));
    en_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (period_end_o !== 1'b1) begin failures++; $display("FAIL per0_pe k=%0d period_end_o=%b expected=1", k, period_end_o); end
      checks++; if (cnt_o !== '0) begin failures++; $display("FAIL per0_cnt k=%0d cnt_o=%0d expected=0", k, cnt_o); end
    end
  endtask

  task automatic test_disable();
    logic          exp_pwm;
    logic [DW-1:0] exp_cnt;
    load_cfg(DW'(9), DW'(3));
    en_i = 1'b1;
    wait_cnt(DW'(4));
    period_i    = DW'(5);
    duty_i      = DW'(1);
    cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    tick();
    checks++; if (cnt_o !== DW'(6)) begin failures++; $display("FAIL dis_cnt6 cnt_o=%0d expected=6", cnt_o); end
    checks++; if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL dis_pending cfg_ready_o=%b expected=0", cfg_ready_o); end
    en_i = 1'b0;
    tick();
    checks++; if (cnt_o !== '0) begin failures++; $display("FAIL dis_cnt cnt_o=%0d expected=0", cnt_o); end
    checks++; if (pwm_o !== 1'b0) begin failures++; $display("FAIL dis_pwm pwm_o=%b expected=0", pwm_o); end
    checks++; if (period_end_o !== 1'b0) begin failures++; $display("FAIL dis_pe period_end_o=%b expected=0", period_end_o); end
    checks++; if (duty_o !== DW'(1)) begin failures++; $display("FAIL dis_commit_duty duty_o=%0d expected=1", duty_o); end
    checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL dis_commit_ready cfg_ready_o=%b expected=1", cfg_ready_o); end
    en_i = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      exp_pwm = ((j - 1) % 6) < 1;
      exp_cnt = DW'(j % 6);
      checks++; if (pwm_o !== exp_pwm) begin failures++; $display("FAIL dis_rerun_pwm j=%0d pwm_o=%b expected=%b", j, pwm_o, exp_pwm); end
      checks++; if (cnt_o !== exp_cnt) begin failures++; $display("FAIL dis_rerun_cnt j=%0d cnt_o=%0d expected=%0d", j, cnt_o, exp_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    load_cfg(DW'(9), DW'(3));
    en_i = 1'b1;
    wait_cnt(DW'(4));
    period_i    = DW'(2);
    duty_i      = DW'(8);
    cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    wait_cnt(DW'(7));
    rst_i = 1'b1;
    tick();
    checks++; if (cnt_o !== '0) begin failures++; $display("FAIL rst_mid_cnt cnt_o=%0d expected=0", cnt_o); end
    checks++; if (duty_o !== '0) begin failures++; $display("FAIL rst_mid_duty duty_o=%0d expected=0", duty_o); end
    checks++; if (pwm_o !== 1'b0) begin failures++; $display("FAIL rst_mid_pwm pwm_o=%b expected=0", pwm_o); end
    checks++; if (period_end_o !== 1'b0) begin failures++; $display("FAIL rst_mid_pe period_end_o=%b expected=0", period_end_o); end
    checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_ready cfg_ready_o=%b expected=1", cfg_ready_o); end
    rst_i = 1'b0;
    en_i  = 1'b0;
    tick();
    checks++; if (duty_o !== '0) begin failures++; $display("FAIL rst_mid_lost duty_o=%0d expected=0", duty_o); end
    checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_idle cfg_ready_o=%b expected=1", cfg_ready_o); end
  endtask

  initial begin
    test_reset();
    test_basic_pwm();
    test_boundary_commit();
    test_duty_edges();
    test_disable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
